// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and the
// width helper used to size the step counter.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // Bits needed to hold values 0..value-1; callers pass DW+1 so the counter can reach DW.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/div_param_if.sv
// Request/result bundle of the divider. The sgn operand exists only when
// DIV_SIGNED_EN is defined.
interface div_param_if #(
  parameter int DW = 4
);
  logic              start;
  logic [2*DW-1:0]   num;
  logic [DW-1:0]     denom;
`ifdef DIV_SIGNED_EN
  logic              sgn;
`endif
  logic [DW-1:0]     quotient;
  logic [DW-1:0]     remainder;
  logic              rdy;
  logic              busy;
  logic              overflow;

  modport master (
`ifdef DIV_SIGNED_EN
    output sgn,
`endif
    output start, num, denom,
    input  quotient, remainder, rdy, busy, overflow
  );

  modport slave (
`ifdef DIV_SIGNED_EN
    input  sgn,
`endif
    input  start, num, denom,
    output quotient, remainder, rdy, busy, overflow
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and emit the quotient bit.
module div_step #(
  parameter int DW = 4
) (
  input  logic [DW-1:0] rem_in,
  input  logic          bit_in,
  input  logic [DW-1:0] den,
  output logic [DW-1:0] rem_out,
  output logic          q_bit
);
  logic [DW:0]   trial;
  logic [DW+1:0] diff;

  always_comb begin
    trial   = {rem_in, bit_in};
    diff    = {1'b0, trial} - {2'b00, den};
    // rem_in < den keeps a successful difference below den, so both top bits are zero.
    q_bit   = (diff[DW+1:DW] == 2'b00);
    rem_out = q_bit ? diff[DW-1:0] : trial[DW-1:0];
  end
endmodule

// File: rtl/div_param.sv
// Iterative restoring divider, 2*DW / DW bits, one quotient bit per cycle.
// Define DIV_SIGNED_EN to add the sgn operand and two's-complement division.
module div_param
  import div_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic         clk,
  input  logic         rst,
  div_param_if.slave   bus
);
  localparam int CW = clog2(DW + 1);

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg;
  logic [DW-1:0]   rem_reg, lo_reg, den_reg;
  logic [DW-1:0]   quotient_reg, remainder_reg;
  logic            rdy_reg, overflow_reg, pre_ovf_reg;

  logic            accept, pre_ovf, last_step;
  logic [2*DW-1:0] num_mag;
  logic [DW-1:0]   den_mag;
  logic [DW-1:0]   step_rem;
  logic            step_q;
  logic [DW-1:0]   q_final, r_final;
  logic            ovf_final;

`ifdef DIV_SIGNED_EN
  localparam logic [DW-1:0] Q_LIM = {1'b1, {(DW-1){1'b0}}};
  logic num_neg, den_neg;
  logic sgn_reg, neg_q_reg, neg_r_reg;

  assign num_neg   = bus.sgn & bus.num[2*DW-1];
  assign den_neg   = bus.sgn & bus.denom[DW-1];
  assign num_mag   = num_neg ? -bus.num : bus.num;
  assign den_mag   = den_neg ? -bus.denom : bus.denom;
  assign q_final   = neg_q_reg ? -lo_reg : lo_reg;
  assign r_final   = neg_r_reg ? -rem_reg : rem_reg;
  // A negative quotient may reach -2^(DW-1); a positive one stops at 2^(DW-1)-1.
  assign ovf_final = pre_ovf_reg |
                     (sgn_reg & (neg_q_reg ? (lo_reg > Q_LIM) : (lo_reg > Q_LIM - 1'b1)));
`else
  assign num_mag   = bus.num;
  assign den_mag   = bus.denom;
  assign q_final   = lo_reg;
  assign r_final   = rem_reg;
  assign ovf_final = pre_ovf_reg;
`endif

  // DONE only takes a new request once its result has been published.
  assign accept    = bus.start & ((state_reg == IDLE) | ((state_reg == DONE) & rdy_reg));
  assign pre_ovf   = (den_mag == '0) | (num_mag[2*DW-1:DW] >= den_mag);
  assign last_step = (cnt_reg == CW'(DW - 1));

  div_step #(.DW(DW)) u_step (
    .rem_in  (rem_reg),
    .bit_in  (lo_reg[DW-1]),
    .den     (den_reg),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (accept) state_next = pre_ovf ? DONE : CALC;
      CALC:       if (last_step) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg       <= '0;
      rem_reg       <= '0;
      lo_reg        <= '0;
      den_reg       <= '0;
      pre_ovf_reg   <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      rdy_reg       <= 1'b0;
      overflow_reg  <= 1'b0;
`ifdef DIV_SIGNED_EN
      sgn_reg       <= 1'b0;
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
`endif
    end else if (accept) begin
      rem_reg      <= num_mag[2*DW-1:DW];
      lo_reg       <= num_mag[DW-1:0];
      den_reg      <= den_mag;
      pre_ovf_reg  <= pre_ovf;
      cnt_reg      <= '0;
      rdy_reg      <= 1'b0;
      overflow_reg <= 1'b0;
`ifdef DIV_SIGNED_EN
      sgn_reg      <= bus.sgn;
      neg_q_reg    <= num_neg ^ den_neg;
      neg_r_reg    <= num_neg;
`endif
    end else if (state_reg == CALC) begin
      rem_reg <= step_rem;
      lo_reg  <= {lo_reg[DW-2:0], step_q};
      cnt_reg <= cnt_reg + CW'(1);
    end else if ((state_reg == DONE) && !rdy_reg) begin
      rdy_reg       <= 1'b1;
      overflow_reg  <= ovf_final;
      quotient_reg  <= ovf_final ? '1 : q_final;
      remainder_reg <= ovf_final ? '1 : r_final;
    end
  end

  assign bus.quotient  = quotient_reg;
  assign bus.remainder = remainder_reg;
  assign bus.rdy       = rdy_reg;
  assign bus.busy      = (state_reg == CALC);
  assign bus.overflow  = overflow_reg;
endmodule

// File: tb/tb_div_param.sv
// Scoreboard bench for div_param at DW=4: directed cases, ignored start,
// mid-operation reset and an exhaustive unsigned sweep.
module tb_div_param;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_param_if #(.DW(DW)) bus_if ();
  div_param #(.DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus_if.slave));

  typedef struct {
    logic [7:0] num;
    logic [3:0] den;
    logic [3:0] q;
    logic [3:0] r;
    logic       ovf;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  logic sgn_val = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void ref_div(input logic [7:0] n, input logic [3:0] d, input logic sg,
                                  output exp_t e);
    int ni, di, qi, ri;
    e.num = n; e.den = d; e.q = '0; e.r = '0; e.ovf = 1'b0;
    if (sg) begin
      ni = int'($signed(n));
      di = int'($signed(d));
    end else begin
      ni = int'(n);
      di = int'(d);
    end
    if (di == 0) begin
      e.ovf = 1'b1;
    end else begin
      qi = ni / di;
      ri = ni % di;
      e.ovf = sg ? (qi < -8 || qi > 7) : (qi > 15);
      e.q = qi[3:0];
      e.r = ri[3:0];
    end
  endfunction

  // Called away from a clock edge; inject_at>0 pulses a stray start before that CALC edge.
  task automatic run_op(input logic [7:0] n, input logic [3:0] d, input int inject_at,
                        input string name);
    exp_t e;
    int   lat, busy_cnt;
    logic seen;
    ref_div(n, d, sgn_val, e);
    sb_q.push_back(e);
    bus_if.start = 1'b1;
    bus_if.num   = n;
    bus_if.denom = d;
`ifdef DIV_SIGNED_EN
    bus_if.sgn   = sgn_val;
`endif
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    check_val({name, "_rdy_drop"}, 32'(bus_if.rdy), 32'd0);
    lat = 0; busy_cnt = 0; seen = 1'b0;
    if (bus_if.busy) busy_cnt++;
    for (int k = 1; k <= 20 && !seen; k++) begin
      if (k == inject_at) begin
        bus_if.start = 1'b1;
        bus_if.num   = 8'h21;
        bus_if.denom = 4'h4;
      end
      @(posedge clk); #1;
      bus_if.start = 1'b0;
      lat = k;
      if (bus_if.rdy) seen = 1'b1;
      else if (bus_if.busy) busy_cnt++;
    end
    e = sb_q.pop_front();
    check_val({name, "_rdy_seen"}, 32'(seen), 32'd1);
    check_val({name, "_latency"}, 32'(lat), e.ovf ? 32'd1 : 32'(DW + 1));
    check_val({name, "_busy_cycles"}, 32'(busy_cnt), e.ovf ? 32'd0 : 32'(DW));
    check_val({name, "_overflow"}, 32'(bus_if.overflow), 32'(e.ovf));
    if (!e.ovf) begin
      check_val({name, "_quotient"}, 32'(bus_if.quotient), 32'(e.q));
      check_val({name, "_remainder"}, 32'(bus_if.remainder), 32'(e.r));
    end
    $display("[TB] %s num=0x%02h den=0x%0h sgn=%0b -> q=0x%0h r=0x%0h ovf=%0b lat=%0d",
             name, n, d, sgn_val, bus_if.quotient, bus_if.remainder, bus_if.overflow, lat);
  endtask

  initial begin
    logic late_rdy;
    rst = 1'b0;
    bus_if.start = 1'b0;
    bus_if.num   = '0;
    bus_if.denom = '0;
`ifdef DIV_SIGNED_EN
    bus_if.sgn   = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_quotient", 32'(bus_if.quotient), 32'd0);
    check_val("reset_remainder", 32'(bus_if.remainder), 32'd0);
    check_val("reset_rdy", 32'(bus_if.rdy), 32'd0);
    check_val("reset_busy", 32'(bus_if.busy), 32'd0);
    check_val("reset_overflow", 32'(bus_if.overflow), 32'd0);

    // Start is raised together with reset release, so the first edge samples it.
    @(negedge clk);
    rst = 1'b1;
    run_op(8'h64, 4'h7, 0, "basic");
    repeat (3) @(posedge clk);
    #1;
    check_val("hold_quotient", 32'(bus_if.quotient), 32'hE);
    check_val("hold_remainder", 32'(bus_if.remainder), 32'h2);
    check_val("hold_rdy", 32'(bus_if.rdy), 32'd1);

    run_op(8'h10, 4'h1, 0, "ovf_hi_eq");
    run_op(8'h3C, 4'h0, 0, "ovf_div0");
    run_op(8'hFF, 4'hF, 0, "ovf_max");
    run_op(8'hEF, 4'hF, 0, "max_quot");
    run_op(8'h00, 4'h1, 0, "zero_num");
    run_op(8'h64, 4'h7, 2, "ignore_start");

    // Abort an operation in its second CALC cycle.
    bus_if.start = 1'b1;
    bus_if.num   = 8'h64;
    bus_if.denom = 4'h7;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_val("abort_quotient", 32'(bus_if.quotient), 32'd0);
    check_val("abort_remainder", 32'(bus_if.remainder), 32'd0);
    check_val("abort_rdy", 32'(bus_if.rdy), 32'd0);
    check_val("abort_busy", 32'(bus_if.busy), 32'd0);
    check_val("abort_overflow", 32'(bus_if.overflow), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    late_rdy = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus_if.rdy) late_rdy = 1'b1;
    end
    check_val("abort_no_rdy", 32'(late_rdy), 32'd0);
    run_op(8'h21, 4'h4, 0, "post_abort");

`ifdef DIV_SIGNED_EN
    sgn_val = 1'b1;
    run_op(8'hF9, 4'h2, 0, "signed_neg");
    run_op(8'h80, 4'hF, 0, "signed_ovf");
    sgn_val = 1'b0;
`endif

    for (int n = 0; n < 256; n++) begin
      for (int d = 0; d < 16; d++) begin
        run_op(8'(n), 4'(d), 0, "sweep");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
